// File: rtl/led_mem_arbiter.sv
// led_mem_arbiter: two-requester arbiter in front of a single-port BRAM.
//
// Each rising edge picks at most one eligible requester (req high and not
// granted at the previous edge) and registers a one-cycle memory command
// (ena/wea/addra/dina) together with a one-cycle grant pulse. Reads return
// through a 2-stage {valid,id} shift so data comes back two edges after the
// grant, in grant order.
//
// Build option:
//   LED_MEM_ARB_RR_EN  defined   -> round-robin on contention (the requester
//                                   not most recently granted wins)
//                      undefined -> fixed priority, requester 0 wins
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req0/1, we0/1             request, 1 = write / 0 = read
//   addr0/1, wdata0/1         access address and write data
//   gnt0/1                    one-cycle grant pulse
//   rvalid0/1, rdata          one-cycle read return, rdata held otherwise
//   busy                      access or read return in flight
//   ena, wea, addra, dina     BRAM command port
//   douta                     BRAM read data, valid one cycle after the read
module led_mem_arbiter #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          ena,
  output logic          wea,
  output logic [AW-1:0] addra,
  output logic [DW-1:0] dina,
  input  logic [DW-1:0] douta
);

  logic          gnt0_q, gnt1_q, gnt0_d, gnt1_d;
  logic          ena_q, wea_q, ena_d, wea_d;
  logic [AW-1:0] addra_q, addra_d;
  logic [DW-1:0] dina_q, dina_d;
  logic          rvalid0_q, rvalid1_q, rvalid0_d, rvalid1_d;
  logic [DW-1:0] rdata_q, rdata_d;
  // Read-return shift: stage 0 loads with the grant, stage 1 one edge later
  // (BRAM sampling the command), rvalid/rdata register on the next edge.
  logic [1:0]    vld_pipe_q, vld_pipe_d;
  logic [1:0]    id_pipe_q, id_pipe_d;
  logic          elig0, elig1, prio0;

`ifdef LED_MEM_ARB_RR_EN
  // 1 = requester 1 was granted most recently; reset to 1 so requester 0
  // wins the first contention.
  logic last1_q;
  assign prio0 = last1_q;
  always_ff @(posedge clk) begin
    if (rst)        last1_q <= 1'b1;
    else if (ena_d) last1_q <= gnt1_d;
  end
`else
  assign prio0 = 1'b1;
`endif

  always_comb begin
    // The registered grant doubles as the "granted at previous edge" mask.
    elig0 = req0 & ~gnt0_q;
    elig1 = req1 & ~gnt1_q;
    gnt0_d = elig0 & (~elig1 | prio0);
    gnt1_d = elig1 & ~gnt0_d;

    ena_d   = gnt0_d | gnt1_d;
    wea_d   = 1'b0;
    addra_d = addra_q;
    dina_d  = dina_q;
    if (gnt0_d) begin
      wea_d   = we0;
      addra_d = addr0;
      dina_d  = wdata0;
    end else if (gnt1_d) begin
      wea_d   = we1;
      addra_d = addr1;
      dina_d  = wdata1;
    end

    vld_pipe_d = {vld_pipe_q[0], ena_d & ~wea_d};
    id_pipe_d  = {id_pipe_q[0], gnt1_d};

    rvalid0_d = vld_pipe_q[1] & ~id_pipe_q[1];
    rvalid1_d = vld_pipe_q[1] &  id_pipe_q[1];
    rdata_d   = vld_pipe_q[1] ? douta : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      ena_q      <= 1'b0;
      wea_q      <= 1'b0;
      addra_q    <= '0;
      dina_q     <= '0;
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      ena_q      <= ena_d;
      wea_q      <= wea_d;
      addra_q    <= addra_d;
      dina_q     <= dina_d;
      vld_pipe_q <= vld_pipe_d;
      id_pipe_q  <= id_pipe_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata_q    <= rdata_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign ena     = ena_q;
  assign wea     = wea_q;
  assign addra   = addra_q;
  assign dina    = dina_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = rdata_q;
  assign busy    = ena_q | vld_pipe_q[0] | vld_pipe_q[1];

endmodule

// File: tb/tb_led_mem_arbiter.sv
// Bench for led_mem_arbiter: directed scenarios then random traffic, every
// cycle compared against a transaction-level reference model (shadow memory
// plus a queue of outstanding read returns with due cycles).
module tb_led_mem_arbiter;
  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy, ena, wea;
  logic [DW-1:0] rdata, dina;
  logic [AW-1:0] addra;
  logic [DW-1:0] douta;

  led_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy), .ena(ena), .wea(wea),
    .addra(addra), .dina(dina), .douta(douta)
  );

  always #5 clk = ~clk;

  // Single-port BRAM behaviour: read data one cycle after the read edge.
  logic [DW-1:0] bram [16];
  always @(posedge clk) begin
    if (ena) begin
      if (wea) bram[addra] <= dina;
      else     douta <= bram[addra];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0]   due;
    logic          id;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           pend[$];
  logic [DW-1:0] m_mem [16];
  logic          m_pg0, m_pg1, m_last1;
  int            cyc = 0;
  logic          e_gnt0, e_gnt1, e_ena, e_wea, e_rv0, e_rv1, e_busy;
  logic [AW-1:0] e_addra;
  logic [DW-1:0] e_dina, e_rdata;

  // Predict the edge from the current inputs, clock it, compare.
  task automatic step();
    int  pick;
    logic e0, e1, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    rd_t r;
    if (rst) begin
      pend.delete();
      m_pg0 = 0; m_pg1 = 0; m_last1 = 1;
      e_gnt0 = 0; e_gnt1 = 0; e_ena = 0; e_wea = 0; e_rv0 = 0; e_rv1 = 0;
      e_busy = 0; e_addra = '0; e_dina = '0; e_rdata = '0;
    end else begin
      e0 = req0 && !m_pg0;
      e1 = req1 && !m_pg1;
      pick = -1;
      if (e0 && e1) begin
`ifdef LED_MEM_ARB_RR_EN
        pick = m_last1 ? 0 : 1;
`else
        pick = 0;
`endif
      end else if (e0) pick = 0;
      else if (e1) pick = 1;
      e_rv0 = 0; e_rv1 = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        if (r.id) e_rv1 = 1; else e_rv0 = 1;
        e_rdata = r.data;
      end
      e_gnt0 = (pick == 0);
      e_gnt1 = (pick == 1);
      e_ena  = (pick >= 0);
      e_wea  = 0;
      if (pick >= 0) begin
        w = (pick == 1) ? we1 : we0;
        a = (pick == 1) ? addr1 : addr0;
        d = (pick == 1) ? wdata1 : wdata0;
        e_wea = w; e_addra = a; e_dina = d;
        if (w) m_mem[a] = d;
        else   pend.push_back('{due: cyc + 2, id: (pick == 1), data: m_mem[a]});
        m_last1 = (pick == 1);
      end
      m_pg0 = e_gnt0; m_pg1 = e_gnt1;
      e_busy = e_ena || (pend.size() > 0);
    end
    @(posedge clk); #1;
    chk("gnt0", gnt0, e_gnt0);
    chk("gnt1", gnt1, e_gnt1);
    chk("ena", ena, e_ena);
    chk("wea", wea, e_wea);
    chk("addra", addra, e_addra);
    chk("dina", dina, e_dina);
    chk("rvalid0", rvalid0, e_rv0);
    chk("rvalid1", rvalid1, e_rv1);
    chk("rdata", rdata, e_rdata);
    chk("busy", busy, e_busy);
    cyc++;
  endtask

  // Random requester: start a new request when idle or just granted.
  task automatic drive_rand(input logic granted, inout logic rq, inout logic we,
                            inout logic [AW-1:0] ad, inout logic [DW-1:0] wd);
    if (!rq || granted) begin
      if ($urandom_range(0, 9) < 7) begin
        rq = 1;
        we = $urandom_range(0, 1) == 1;
        ad = AW'($urandom_range(0, 15));
        wd = DW'($urandom);
      end else begin
        rq = 0;
      end
    end
  endtask

  initial begin
    int rv_seen;
    int ngnt;
    for (int i = 0; i < 16; i++) begin
      bram[i] = '0;
      m_mem[i] = '0;
    end
    douta = '0;
    rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    #2;
    step(); step();
    chk("rst_busy", busy, 0);
    rst = 0;

    // Single write
    req0 = 1; we0 = 1; addr0 = 4'd3; wdata0 = 16'hA5A5;
    step();
    chk("wr_gnt0", gnt0, 1);
    chk("wr_addra", addra, 3);
    chk("wr_dina", dina, 16'hA5A5);
    req0 = 0; we0 = 0;
    step(); step();

    // Read back through requester 1
    req1 = 1; we1 = 0; addr1 = 4'd3;
    step();
    chk("rd_gnt1", gnt1, 1);
    req1 = 0;
    step();
    step();
    chk("rd_rvalid1", rvalid1, 1);
    chk("rd_rdata", rdata, 16'hA5A5);
    step(); step();

    // Contention: both reading, held 6 cycles
    req0 = 1; we0 = 0; addr0 = 4'd1;
    req1 = 1; we1 = 0; addr1 = 4'd2;
    step();
    chk("cont_first_gnt0", gnt0, 1);
    for (int i = 0; i < 5; i++) step();
    req0 = 0; req1 = 0;
    for (int i = 0; i < 4; i++) step();

    // Single requester streaming addresses 0..2
    req0 = 1; we0 = 0; addr0 = 4'd0;
    ngnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (e_gnt0) begin
        ngnt++;
        addr0 = addr0 + 4'd1;
      end
    end
    chk("stream_grants", ngnt, 3);
    req0 = 0;
    for (int i = 0; i < 4; i++) step();

    // Reset one cycle after a read grant: the return must vanish
    req0 = 1; we0 = 0; addr0 = 4'd3;
    step();
    chk("mr_gnt0", gnt0, 1);
    req0 = 0; rst = 1;
    step();
    chk("mr_rdata0", rdata, 0);
    rst = 0;
    rv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rvalid0) rv_seen++;
    end
    chk("mr_no_rvalid", rv_seen, 0);

    // Idle
    for (int i = 0; i < 10; i++) step();
    chk("idle_busy", busy, 0);

    // Random traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      drive_rand(e_gnt0, req0, we0, addr0, wdata0);
      drive_rand(e_gnt1, req1, we1, addr1, wdata1);
      rst = ($urandom_range(0, 99) < 2);
      step();
      if (rst) begin
        req0 = 0; req1 = 0;
      end
    end
    rst = 0; req0 = 0; req1 = 0;
    for (int i = 0; i < 4; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
